// File: rtl/flash_responder.sv
// flash_responder: SPI fast-read flash target; decodes cmd/addr/dummy on spi0,
// fetches one word from a synchronous memory port and returns it MSB-first on spi1.
module flash_responder #(
  parameter int          DUMMY_NUMBER = 15,
  parameter int          MEM_LATENCY  = 1,
  parameter logic [7:0]  CMD_READ     = 8'h0B
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_sel,
  input  logic        spi0,
  output logic        spi1,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        cmd_err,
  output logic        xfer_done
);
  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam logic [4:0] DLAST = 5'(DUMMY_NUMBER - 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
  state_t r_state, w_next;
  logic          w_sample, w_shift, w_load;
  logic [4:0]    r_cnt;
  logic [7:0]    r_cmd;
  logic [23:0]   r_addr, r_mem_addr;
  logic [31:0]   r_tx;
  logic [LW-1:0] r_lat;
  logic          r_pend, r_spi1, r_mem_rd, r_cmd_err, r_xfer_done;
  assign w_sample = !spi_sel && !spi_clk;
  assign w_shift  = !spi_sel && spi_clk;
  assign w_load   = r_pend && r_lat == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!spi_sel) w_next = CMD;
      CMD:     if (w_sample && r_cnt == 5'd7)
                 w_next = ({r_cmd[6:0], spi0} == CMD_READ) ? ADDR : IGNORE;
      ADDR:    if (w_sample && r_cnt == 5'd23) w_next = DUMMY;
      DUMMY:   if (w_sample && r_cnt == DLAST) w_next = DATA;
      DATA:    if (w_sample && r_cnt == 5'd31) w_next = IGNORE;
      default: w_next = r_state;
    endcase
    if (spi_sel) w_next = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt       <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_mem_addr  <= '0;
      r_tx        <= '0;
      r_lat       <= '0;
      r_pend      <= 1'b0;
      r_spi1      <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_xfer_done <= 1'b0;
    end else begin
      r_mem_rd    <= 1'b0;
      r_cmd_err   <= r_state == CMD && w_next == IGNORE;
      r_xfer_done <= r_state == DATA && w_next == IGNORE;
      r_cnt       <= (w_next != r_state) ? 5'd0 : r_cnt + {4'd0, w_sample};
      if (r_state == CMD && w_sample) r_cmd <= {r_cmd[6:0], spi0};
      if (r_state == ADDR && w_sample) r_addr <= {r_addr[22:0], spi0};
      if (r_state == ADDR && w_next == DUMMY) begin
        r_mem_rd   <= 1'b1;
        r_mem_addr <= {r_addr[22:0], spi0};
        r_pend     <= 1'b1;
        r_lat      <= LW'(MEM_LATENCY);
      end else if (r_pend) begin
        r_pend <= !w_load;
        r_lat  <= w_load ? r_lat : r_lat - 1'b1;
      end
      if (r_state == DATA && w_shift) begin
        r_spi1 <= r_tx[31];
        r_tx   <= {r_tx[30:0], 1'b0};
      end else if (w_load) r_tx <= mem_rdata;
      // deselect abandons everything; an in-flight memory read is simply never loaded
      if (spi_sel) begin
        r_cnt  <= '0;
        r_cmd  <= '0;
        r_addr <= '0;
        r_tx   <= '0;
        r_lat  <= '0;
        r_pend <= 1'b0;
        r_spi1 <= 1'b0;
      end
    end
  always_comb begin
    spi1      = r_state == DATA && r_spi1;
    mem_rd    = r_mem_rd;
    mem_addr  = r_mem_addr;
    cmd_err   = r_cmd_err;
    xfer_done = r_xfer_done;
  end
endmodule
